display_scroller: RTL and testbench

- Parametrised successor to the fixed 32-bit scrolling display driver.
- Latches a DATA_W-bit hex value plus sign into a shadow register.
- Presents a DIGITS-wide window of 5-bit digit codes that scrolls right-to-left across a sign/nibble stream.
- Sits between the calculator result path and the 7-segment digit multiplexer; adds hold, manual-step and reload modes.

---
 rtl/display_scroller_pkg.sv | 22 ++
 rtl/display_scroller_prescaler.sv | 44 ++++
 rtl/display_scroller.sv | 116 +++++++++++
 tb/tb_display_scroller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scroller_pkg.sv
// Shared digit codes, mode encodings and sizing helpers for the scrolling display.
package display_pkg;

    localparam int DIGIT_W = 5;

    localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 5'b11111;
    localparam logic [DIGIT_W-1:0] DIGIT_MINUS = 5'b10001;

    // 2'b11 is not a distinct mode; the scroller treats it exactly like hold.
    typedef enum logic [1:0] {
        MODE_AUTO     = 2'b00,
        MODE_HOLD     = 2'b01,
        MODE_MANUAL   = 2'b10,
        MODE_HOLD_ALT = 2'b11
    } mode_e;

    // Width of the position register; a single-position window still gets one bit.
    function automatic int pos_width(input int npos);
        return (npos <= 1) ? 1 : $clog2(npos);
    endfunction

endpackage

// File: rtl/display_scroller_prescaler.sv
// Auto-scroll prescaler: counts 0..TICK_DIV-1 while enabled, holds otherwise.
module scroll_prescaler
    import display_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int            CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count while enabled and roll over at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        tick  = enable && (cnt_q == CNT_MAX);
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scroller.sv
// Scrolling hex display driver: shadows a signed value and slides a DIGITS-wide
// window over the stream {blanks, sign, nibbles}, with auto/hold/manual stepping.
module display_scroller
    import display_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 25_000_000,
    parameter int NIB      = DATA_W / 4,
    parameter int NPOS     = NIB,
    parameter int POS_W    = pos_width(NPOS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      is_negative,
    input  logic                      load,
    input  logic [1:0]                mode,
    input  logic                      step,
    output logic [DIGIT_W*DIGITS-1:0] digits_out,
    output logic                      dp_out,
    output logic [POS_W-1:0]          pos_out,
    output logic                      wrap
);

    localparam int               L        = DIGITS - 1 + NIB;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NPOS - 1);

    logic [POS_W-1:0]  pos_q,  pos_d;
    logic [DATA_W-1:0] val_q,  val_d;
    logic              neg_q,  neg_d;
    logic              wrap_q, wrap_d;

    logic tick;
    logic advance;
    logic auto_en;

    logic [DIGIT_W-1:0] stream [L];

    assign auto_en = (mode == MODE_AUTO);

    scroll_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (auto_en),
        .clear  (load),
        .tick   (tick)
    );

    // Next state: load beats any advance and suppresses the wrap pulse.
    always_comb begin
        pos_d   = pos_q;
        val_d   = val_q;
        neg_d   = neg_q;
        wrap_d  = 1'b0;
        advance = (auto_en && tick) || ((mode == MODE_MANUAL) && step);
        if (load) begin
            val_d = data_in;
            neg_d = is_negative;
            pos_d = '0;
        end else if (advance) begin
            if (pos_q == POS_LAST) begin
                pos_d  = '0;
                wrap_d = 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= '0;
            val_q  <= '0;
            neg_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            val_q  <= val_d;
            neg_q  <= neg_d;
            wrap_q <= wrap_d;
        end
    end

    // Build the digit stream from the shadow: leading blanks, sign slot, then nibbles MSB first.
    always_comb begin
        for (int i = 0; i < L; i++) begin
            stream[i] = DIGIT_BLANK;
        end
        stream[DIGITS-2] = neg_q ? DIGIT_MINUS : DIGIT_BLANK;
        for (int j = 0; j < NIB; j++) begin
            stream[DIGITS-1+j] = {1'b0, val_q[4*(NIB-1-j) +: 4]};
        end
    end

    // Window select: stream[pos+k] drives digit k counted from the left (MSB side).
    always_comb begin
        digits_out = '0;
        for (int k = 0; k < DIGITS; k++) begin
            digits_out[(DIGITS-1-k)*DIGIT_W +: DIGIT_W] = DIGIT_BLANK;
            for (int i = 0; i < L; i++) begin
                if (i == int'(pos_q) + k) begin
                    digits_out[(DIGITS-1-k)*DIGIT_W +: DIGIT_W] = stream[i];
                end
            end
        end
    end

    assign dp_out  = (pos_q == POS_LAST);
    assign pos_out = pos_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_display_scroller.sv
// Scoreboard bench: a behavioural model pushes expected outputs every clock,
// a monitor pops and compares; two DUT configurations run side by side.
module tb_display_scroller;

    localparam int CFG_DIG [2] = '{4, 2};
    localparam int CFG_NIB [2] = '{8, 4};
    localparam int CFG_TD  [2] = '{4, 3};

    localparam logic [4:0] BL = 5'h1F;
    localparam logic [4:0] MI = 5'h11;

    typedef struct {
        logic [31:0] dig;
        logic [31:0] dp;
        logic [31:0] pos;
        logic [31:0] wrp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        ld     [2];
    logic [31:0] din    [2];
    logic        neg_in [2];
    logic [1:0]  md     [2];
    logic        stp    [2];

    logic [19:0] a_dig;
    logic        a_dp, a_wrap;
    logic [2:0]  a_pos;
    logic [9:0]  b_dig;
    logic        b_dp, b_wrap;
    logic [1:0]  b_pos;

    int checks = 0;
    int errors = 0;

    int          m_p   [2];
    int          m_cnt [2];
    logic [31:0] m_val [2];
    bit          m_neg [2];
    bit          m_wrap[2];

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    display_scroller #(.DATA_W(32), .DIGITS(4), .TICK_DIV(4)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .is_negative(neg_in[0]),
        .load(ld[0]), .mode(md[0]), .step(stp[0]),
        .digits_out(a_dig), .dp_out(a_dp), .pos_out(a_pos), .wrap(a_wrap)
    );

    display_scroller #(.DATA_W(16), .DIGITS(2), .TICK_DIV(3)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(din[1][15:0]), .is_negative(neg_in[1]),
        .load(ld[1]), .mode(md[1]), .step(stp[1]),
        .digits_out(b_dig), .dp_out(b_dp), .pos_out(b_pos), .wrap(b_wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Window as a flat list: blanks, sign, nibbles; take DIGITS entries from p.
    function automatic logic [31:0] exp_win(input int digits, input int nib,
                                            input logic [31:0] val, input bit neg, input int p);
        int s[$];
        logic [31:0] r;
        for (int i = 0; i < digits - 2; i++) s.push_back(31);
        s.push_back(neg ? 17 : 31);
        for (int j = nib - 1; j >= 0; j--) s.push_back(int'((val >> (4 * j)) & 32'hF));
        r = 0;
        for (int k = 0; k < digits; k++) r = (r << 5) | 32'(s[p + k]);
        return r;
    endfunction

    task automatic model_step(input int i);
        bit adv;
        int td;
        int npos;
        adv  = 0;
        td   = CFG_TD[i];
        npos = CFG_NIB[i];
        m_wrap[i] = 0;
        if (ld[i]) begin
            m_val[i] = din[i];
            m_neg[i] = neg_in[i];
            m_p[i]   = 0;
            m_cnt[i] = 0;
        end else begin
            if (md[i] == 2'd0) begin
                if (m_cnt[i] == td - 1) begin
                    adv = 1;
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i]++;
                end
            end else if (md[i] == 2'd2 && stp[i]) begin
                adv = 1;
            end
            if (adv) begin
                if (m_p[i] == npos - 1) begin
                    m_p[i]    = 0;
                    m_wrap[i] = 1;
                end else begin
                    m_p[i]++;
                end
            end
        end
    endtask

    function automatic exp_t expected(input int i);
        exp_t e;
        e.dig = exp_win(CFG_DIG[i], CFG_NIB[i], m_val[i], m_neg[i], m_p[i]);
        e.dp  = (m_p[i] == CFG_NIB[i] - 1) ? 1 : 0;
        e.pos = m_p[i];
        e.wrp = m_wrap[i] ? 1 : 0;
        return e;
    endfunction

    // Reference model: advance on every clock, reset immediately on rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_p[i] = 0; m_cnt[i] = 0; m_val[i] = 0; m_neg[i] = 0; m_wrap[i] = 0;
            end
        end else begin
            model_step(0);
            model_step(1);
            qa.push_back(expected(0));
            qb.push_back(expected(1));
        end
    end

    // Monitor: compare settled DUT outputs against the oldest expectation.
    always @(posedge clk) begin
        bit was_run;
        exp_t e;
        was_run = rst_n;
        #2;
        if (was_run) begin
            if (qa.size() == 0 || qb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty qa=%0d qb=%0d", qa.size(), qb.size());
            end else begin
                e = qa.pop_front();
                check("a_digits", 32'(a_dig), e.dig);
                check("a_dp",     32'(a_dp),  e.dp);
                check("a_pos",    32'(a_pos), e.pos);
                check("a_wrap",   32'(a_wrap), e.wrp);
                e = qb.pop_front();
                check("b_digits", 32'(b_dig), e.dig);
                check("b_dp",     32'(b_dp),  e.dp);
                check("b_pos",    32'(b_pos), e.pos);
                check("b_wrap",   32'(b_wrap), e.wrp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_b();
        stp[1] = 1'b1;
        cyc(1);
        stp[1] = 1'b0;
    endtask

    initial begin
        int held_pos;
        for (int i = 0; i < 2; i++) begin
            ld[i] = 0; din[i] = 0; neg_in[i] = 0; md[i] = 2'd1; stp[i] = 0;
        end

        cyc(2);
        check("rst_a_digits", 32'(a_dig), 32'({BL, BL, BL, 5'h00}));
        check("rst_a_dp", 32'(a_dp), 0);
        rst_n = 1'b1;

        // Auto scroll of 0x1234ABCD.
        ld[0] = 1; din[0] = 32'h1234ABCD; neg_in[0] = 0; md[0] = 2'd0;
        cyc(1);
        ld[0] = 0;
        check("a_p0", 32'(a_dig), 32'({BL, BL, BL, 5'h01}));
        cyc(4);
        check("a_p1", 32'(a_dig), 32'({BL, BL, 5'h01, 5'h02}));
        cyc(24);
        check("a_p7", 32'(a_dig), 32'({5'h0A, 5'h0B, 5'h0C, 5'h0D}));
        check("a_p7_dp", 32'(a_dp), 1);
        cyc(4);
        check("a_wrap_pos", 32'(a_pos), 0);
        check("a_wrap_hi", 32'(a_wrap), 1);
        cyc(1);
        check("a_wrap_lo", 32'(a_wrap), 0);

        // Load coinciding with the tick at the last position.
        cyc(30);
        check("a_pre_load_pos", 32'(a_pos), 7);
        ld[0] = 1; din[0] = 32'h0000FFFF; neg_in[0] = 1;
        cyc(1);
        ld[0] = 0; md[0] = 2'd2;
        check("a_load_pos", 32'(a_pos), 0);
        check("a_load_wrap", 32'(a_wrap), 0);
        check("a_neg_p0", 32'(a_dig), 32'({BL, BL, MI, 5'h00}));

        // Manual stepping with irregular gaps, including a full lap.
        for (int s = 0; s < 10; s++) begin
            stp[0] = 1; cyc(1); stp[0] = 0;
            if (s == 1) check("a_neg_p2", 32'(a_dig), 32'({MI, 5'h00, 5'h00, 5'h00}));
            cyc($urandom_range(0, 8));
        end

        // Hold freezes position and prescaler; resume continues the count.
        md[0] = 2'd0;
        cyc(2);
        md[0] = 2'd1;
        cyc(1);
        held_pos = int'(a_pos);
        cyc(50);
        check("a_hold_pos", 32'(a_pos), 32'(held_pos));
        md[0] = 2'd0;
        cyc(12);

        // Second configuration: 16-bit, two digits.
        ld[1] = 1; din[1] = 32'h0000BEEF; neg_in[1] = 1; md[1] = 2'd2;
        cyc(1);
        ld[1] = 0;
        check("b_p0", 32'(b_dig), 32'({MI, 5'h0B}));
        check("b_p0_dp", 32'(b_dp), 0);
        step_b();
        check("b_p1", 32'(b_dig), 32'({5'h0B, 5'h0E}));
        step_b();
        check("b_p2", 32'(b_dig), 32'({5'h0E, 5'h0E}));
        check("b_p2_dp", 32'(b_dp), 0);
        step_b();
        check("b_p3", 32'(b_dig), 32'({5'h0E, 5'h0F}));
        check("b_p3_dp", 32'(b_dp), 1);
        step_b();
        check("b_wrap", 32'(b_wrap), 1);
        step_b();
        step_b();
        #3;
        rst_n = 1'b0;
        #1;
        check("b_async_digits", 32'(b_dig), 32'({BL, 5'h00}));
        check("b_async_pos", 32'(b_pos), 0);
        check("a_async_digits", 32'(a_dig), 32'({BL, BL, BL, 5'h00}));
        cyc(2);
        rst_n = 1'b1;

        // Random traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                ld[i]     = ($urandom_range(0, 39) == 0);
                din[i]    = $urandom;
                neg_in[i] = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 19) == 0) md[i] = 2'($urandom_range(0, 3));
                stp[i]    = ($urandom_range(0, 2) == 0);
            end
            cyc(1);
        end
        for (int i = 0; i < 2; i++) begin
            ld[i] = 0; stp[i] = 0;
        end
        cyc(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
